// File: rtl/ysyx_25020037_wbu_if.sv
// Write-back stage bus: LSU result handshake plus decoded fields, GPR write port and the
// committed next-PC handshake toward fetch. Under WBU_DIFFTEST_EN the difftest taps are added.
interface ysyx_25020037_wbu_if;
  logic        lsu_valid;
  logic        wbu_ready;
  logic [31:0] pc;
  logic [31:0] dnpc_in;
  logic [3:0]  rd;
  logic        gpr_we;
  logic        is_read;
  logic        is_write;
  logic [31:0] alu_result;
  logic [31:0] load_data;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        ecall_en;
  logic        mret_en;
  logic        access_fault;
  logic        gpr_wen;
  logic [3:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        wbu_valid;
  logic        ifu_ready;
  logic [31:0] dnpc;
`ifdef WBU_DIFFTEST_EN
  logic        difftest_commit;
  logic [31:0] difftest_pc;
  logic [31:0] difftest_dnpc;
`endif

  // Environment side: LSU and IFU
  modport master (
    output lsu_valid, pc, dnpc_in, rd, gpr_we, is_read, is_write, alu_result, load_data,
    output csr_en, csr_addr, csr_we, csr_wdata, ecall_en, mret_en, access_fault, ifu_ready,
`ifdef WBU_DIFFTEST_EN
    input  difftest_commit, difftest_pc, difftest_dnpc,
`endif
    input  wbu_ready, gpr_wen, gpr_waddr, gpr_wdata, wbu_valid, dnpc
  );

  // Write-back stage side
  modport slave (
    input  lsu_valid, pc, dnpc_in, rd, gpr_we, is_read, is_write, alu_result, load_data,
    input  csr_en, csr_addr, csr_we, csr_wdata, ecall_en, mret_en, access_fault, ifu_ready,
`ifdef WBU_DIFFTEST_EN
    output difftest_commit, difftest_pc, difftest_dnpc,
`endif
    output wbu_ready, gpr_wen, gpr_waddr, gpr_wdata, wbu_valid, dnpc
  );
endinterface

// File: rtl/ysyx_25020037_wbu.sv
// Write-back / commit stage: owns the M-mode CSR file, drives the GPR write port, resolves
// traps and mret, and hands the committed next PC to fetch.
// Optional macro WBU_DIFFTEST_EN adds difftest_commit/difftest_pc/difftest_dnpc outputs.
module ysyx_25020037_wbu #(
  parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
  parameter logic [31:0] MVENDORID     = 32'h7973_7978,
  parameter logic [31:0] MARCHID       = 32'h017D_C685
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_25020037_wbu_if.slave     bus
);

  typedef enum logic [1:0] {StIdle, StCommit, StHold} state_e;

  localparam logic [11:0] AddrMstatus   = 12'h300;
  localparam logic [11:0] AddrMtvec     = 12'h305;
  localparam logic [11:0] AddrMepc      = 12'h341;
  localparam logic [11:0] AddrMcause    = 12'h342;
  localparam logic [11:0] AddrMvendorid = 12'hF11;
  localparam logic [11:0] AddrMarchid   = 12'hF12;

  state_e      state_q, state_d;

  // Captured instruction
  logic [31:0] pc_q, alu_q, load_q, csr_wdata_q, dnpc_q;
  logic [3:0]  rd_q;
  logic [11:0] csr_addr_q;
  logic        gpr_we_q, is_read_q, csr_en_q, csr_we_q, ecall_q, mret_q, fault_q;

  // CSR file
  logic [31:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;

  logic        capture, commit, trap;
  logic [31:0] dnpc_d, csr_rdata, wb_data;
  logic        unused_is_write;

  assign capture = (state_q == StIdle) && bus.lsu_valid;
  assign commit  = (state_q == StCommit);
  assign trap    = fault_q | ecall_q;
  // Store vs. load is fully described by is_read for fault causes.
  assign unused_is_write = bus.is_write;

  // Redirect target is chosen at capture so dnpc is stable for the whole COMMIT/HOLD window.
  always_comb begin
    dnpc_d = bus.dnpc_in;
    if (bus.access_fault || bus.ecall_en) dnpc_d = mtvec_q;
    else if (bus.mret_en)                 dnpc_d = mepc_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.lsu_valid) state_d = StCommit;
      StCommit: state_d = bus.ifu_ready ? StIdle : StHold;
      StHold:   if (bus.ifu_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Capture all upstream fields once, when the handshake completes in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      alu_q       <= '0;
      load_q      <= '0;
      csr_wdata_q <= '0;
      dnpc_q      <= '0;
      rd_q        <= '0;
      csr_addr_q  <= '0;
      gpr_we_q    <= 1'b0;
      is_read_q   <= 1'b0;
      csr_en_q    <= 1'b0;
      csr_we_q    <= 1'b0;
      ecall_q     <= 1'b0;
      mret_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else if (capture) begin
      pc_q        <= bus.pc;
      alu_q       <= bus.alu_result;
      load_q      <= bus.load_data;
      csr_wdata_q <= bus.csr_wdata;
      dnpc_q      <= dnpc_d;
      rd_q        <= bus.rd;
      csr_addr_q  <= bus.csr_addr;
      gpr_we_q    <= bus.gpr_we;
      is_read_q   <= bus.is_read;
      csr_en_q    <= bus.csr_en;
      csr_we_q    <= bus.csr_we;
      ecall_q     <= bus.ecall_en;
      mret_q      <= bus.mret_en;
      fault_q     <= bus.access_fault;
    end
  end

  // Old CSR value, read before the COMMIT write lands
  always_comb begin
    csr_rdata = '0;
    case (csr_addr_q)
      AddrMstatus:   csr_rdata = mstatus_q;
      AddrMtvec:     csr_rdata = mtvec_q;
      AddrMepc:      csr_rdata = mepc_q;
      AddrMcause:    csr_rdata = mcause_q;
      AddrMvendorid: csr_rdata = MVENDORID;
      AddrMarchid:   csr_rdata = MARCHID;
      default:       csr_rdata = '0;
    endcase
  end

  // CSR next state: trap side effects win over any software write
  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (commit) begin
      if (trap) begin
        mepc_d           = pc_q;
        mcause_d         = fault_q ? (is_read_q ? 32'd5 : 32'd7) : 32'd11;
        mstatus_d[7]     = mstatus_q[3];
        mstatus_d[3]     = 1'b0;
        mstatus_d[12:11] = 2'b11;
      end else begin
        if (csr_we_q) begin
          case (csr_addr_q)
            AddrMstatus: mstatus_d = csr_wdata_q;
            AddrMtvec:   mtvec_d   = csr_wdata_q;
            AddrMepc:    mepc_d    = csr_wdata_q;
            AddrMcause:  mcause_d  = csr_wdata_q;
            default:     ;
          endcase
        end
        if (mret_q) begin
          mstatus_d[3] = mstatus_q[7];
          mstatus_d[7] = 1'b1;
        end
      end
    end
  end

  // CSR registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q <= RESET_MSTATUS;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  // Write-back data select
  always_comb begin
    wb_data = alu_q;
    if (is_read_q)     wb_data = load_q;
    else if (csr_en_q) wb_data = csr_rdata;
  end

  assign bus.wbu_ready = (state_q == StIdle);
  assign bus.wbu_valid = (state_q == StCommit) || (state_q == StHold);
  assign bus.dnpc      = dnpc_q;
  // Qualified with rst so a commit cut short by reset never writes
  assign bus.gpr_wen   = commit & gpr_we_q & (rd_q != 4'd0) & ~trap & ~rst;
  assign bus.gpr_waddr = commit ? rd_q : 4'd0;
  assign bus.gpr_wdata = commit ? wb_data : 32'd0;

`ifdef WBU_DIFFTEST_EN
  assign bus.difftest_commit = commit & ~rst;
  assign bus.difftest_pc     = rst ? 32'd0 : pc_q;
  assign bus.difftest_dnpc   = rst ? 32'd0 : dnpc_q;
`endif

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// Directed bench for the write-back stage: reset, load with fetch stall, CSR access,
// ecall/mret, access faults, rd=0, read-only CSRs, back-to-back commits, reset in HOLD.
module tb_ysyx_25020037_wbu;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [31:0] rdata;

  ysyx_25020037_wbu_if bus ();

  ysyx_25020037_wbu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.lsu_valid    = 1'b0;
    bus.pc           = '0;
    bus.dnpc_in      = '0;
    bus.rd           = '0;
    bus.gpr_we       = 1'b0;
    bus.is_read      = 1'b0;
    bus.is_write     = 1'b0;
    bus.alu_result   = '0;
    bus.load_data    = '0;
    bus.csr_en       = 1'b0;
    bus.csr_addr     = '0;
    bus.csr_we       = 1'b0;
    bus.csr_wdata    = '0;
    bus.ecall_en     = 1'b0;
    bus.mret_en      = 1'b0;
    bus.access_fault = 1'b0;
  endtask

  // Present the prepared instruction for one edge; returns in the COMMIT cycle
  task automatic fire();
    bus.lsu_valid = 1'b1;
    step();
    bus.lsu_valid = 1'b0;
  endtask

  // csrrs rX, addr, x0 : returns old CSR value seen on the GPR write port, then back to IDLE
  task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
    clear();
    bus.csr_en   = 1'b1;
    bus.csr_addr = addr;
    bus.rd       = 4'd1;
    bus.gpr_we   = 1'b1;
    fire();
    data = bus.gpr_wdata;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ifu_ready = 1'b1;
    clear();
    step();
    step();
    rst = 1'b0;
    checks++;
    if (bus.wbu_ready !== 1'b1 || bus.wbu_valid !== 1'b0 || bus.gpr_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: ready=%b valid=%b wen=%b required 1 0 0",
               bus.wbu_ready, bus.wbu_valid, bus.gpr_wen);
    end
    checks++;
    if (bus.dnpc !== 32'd0 || bus.gpr_wdata !== 32'd0 || bus.gpr_waddr !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: dnpc=%h wdata=%h waddr=%h required zeros",
               bus.dnpc, bus.gpr_wdata, bus.gpr_waddr);
    end
    // csrrs x5, mstatus, x0
    clear();
    bus.csr_en   = 1'b1;
    bus.csr_addr = 12'h300;
    bus.rd       = 4'd5;
    bus.gpr_we   = 1'b1;
    fire();
    checks++;
    if (bus.gpr_wen !== 1'b1 || bus.gpr_waddr !== 4'd5 || bus.gpr_wdata !== 32'h0000_1800) begin
      errors++;
      $display("FAIL reset_mstatus_read: wen=%b waddr=%0d wdata=%h required 1 5 00001800",
               bus.gpr_wen, bus.gpr_waddr, bus.gpr_wdata);
    end
    step();
    checks++;
    if (bus.gpr_wen !== 1'b0 || bus.wbu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wen_single: wen=%b ready=%b required 0 1", bus.gpr_wen, bus.wbu_ready);
    end
  endtask

  task automatic test_load_hold();
    clear();
    bus.pc        = 32'h8000_0010;
    bus.dnpc_in   = 32'h8000_0014;
    bus.rd        = 4'd3;
    bus.gpr_we    = 1'b1;
    bus.is_read   = 1'b1;
    bus.load_data = 32'hFFFF_FF80;
    bus.alu_result = 32'h8000_0100;
    bus.ifu_ready = 1'b0;
    fire();
    checks++;
    if (bus.gpr_wen !== 1'b1 || bus.gpr_waddr !== 4'd3 || bus.gpr_wdata !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL load_write: wen=%b waddr=%0d wdata=%h required 1 3 ffffff80",
               bus.gpr_wen, bus.gpr_waddr, bus.gpr_wdata);
    end
    checks++;
    if (bus.wbu_valid !== 1'b1 || bus.dnpc !== 32'h8000_0014 || bus.wbu_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_commit: valid=%b dnpc=%h ready=%b required 1 80000014 0",
               bus.wbu_valid, bus.dnpc, bus.wbu_ready);
    end
    // Three HOLD cycles; fetch accepts during the last one
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) bus.ifu_ready = 1'b1;
      checks++;
      if (bus.wbu_valid !== 1'b1 || bus.dnpc !== 32'h8000_0014 || bus.wbu_ready !== 1'b0 ||
          bus.gpr_wen !== 1'b0) begin
        errors++;
        $display("FAIL load_hold%0d: valid=%b dnpc=%h ready=%b wen=%b required 1 80000014 0 0",
                 i, bus.wbu_valid, bus.dnpc, bus.wbu_ready, bus.gpr_wen);
      end
    end
    step();
    checks++;
    if (bus.wbu_valid !== 1'b0 || bus.wbu_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_release: valid=%b ready=%b required 0 1", bus.wbu_valid, bus.wbu_ready);
    end
  endtask

  task automatic test_trap();
    // csrrw x2, mtvec : old value 0
    clear();
    bus.csr_en    = 1'b1;
    bus.csr_we    = 1'b1;
    bus.csr_addr  = 12'h305;
    bus.csr_wdata = 32'h8000_1000;
    bus.rd        = 4'd2;
    bus.gpr_we    = 1'b1;
    fire();
    checks++;
    if (bus.gpr_wdata !== 32'd0 || bus.gpr_wen !== 1'b1) begin
      errors++;
      $display("FAIL mtvec_old: wdata=%h wen=%b required 00000000 1", bus.gpr_wdata, bus.gpr_wen);
    end
    step();
    // mstatus = MIE only, MPP=00
    clear();
    bus.csr_en    = 1'b1;
    bus.csr_we    = 1'b1;
    bus.csr_addr  = 12'h300;
    bus.csr_wdata = 32'h0000_0008;
    fire();
    step();
    // ecall
    clear();
    bus.pc         = 32'h8000_0020;
    bus.dnpc_in    = 32'h8000_0024;
    bus.ecall_en   = 1'b1;
    bus.rd         = 4'd7;
    bus.gpr_we     = 1'b1;
    bus.alu_result = 32'h0000_1234;
    fire();
    checks++;
    if (bus.dnpc !== 32'h8000_1000 || bus.gpr_wen !== 1'b0 || bus.wbu_valid !== 1'b1) begin
      errors++;
      $display("FAIL ecall_commit: dnpc=%h wen=%b valid=%b required 80001000 0 1",
               bus.dnpc, bus.gpr_wen, bus.wbu_valid);
    end
    step();
    csr_read(12'h341, rdata);
    checks++;
    if (rdata !== 32'h8000_0020) begin
      errors++;
      $display("FAIL ecall_mepc: got %h required 80000020", rdata);
    end
    csr_read(12'h342, rdata);
    checks++;
    if (rdata !== 32'd11) begin
      errors++;
      $display("FAIL ecall_mcause: got %h required 0000000b", rdata);
    end
    csr_read(12'h300, rdata);
    checks++;
    if (rdata !== 32'h0000_1880) begin
      errors++;
      $display("FAIL ecall_mstatus: got %h required 00001880", rdata);
    end
    // mret
    clear();
    bus.pc      = 32'h8000_1010;
    bus.dnpc_in = 32'h8000_1014;
    bus.mret_en = 1'b1;
    fire();
    checks++;
    if (bus.dnpc !== 32'h8000_0020) begin
      errors++;
      $display("FAIL mret_dnpc: got %h required 80000020", bus.dnpc);
    end
    step();
    csr_read(12'h300, rdata);
    checks++;
    if (rdata !== 32'h0000_1888) begin
      errors++;
      $display("FAIL mret_mstatus: got %h required 00001888", rdata);
    end
  endtask

  task automatic test_fault();
    clear();
    bus.pc           = 32'h8000_0030;
    bus.dnpc_in      = 32'h8000_0034;
    bus.is_write     = 1'b1;
    bus.access_fault = 1'b1;
    fire();
    checks++;
    if (bus.dnpc !== 32'h8000_1000 || bus.gpr_wen !== 1'b0) begin
      errors++;
      $display("FAIL store_fault_commit: dnpc=%h wen=%b required 80001000 0", bus.dnpc, bus.gpr_wen);
    end
    step();
    csr_read(12'h342, rdata);
    checks++;
    if (rdata !== 32'd7) begin
      errors++;
      $display("FAIL store_fault_mcause: got %h required 00000007", rdata);
    end
    csr_read(12'h341, rdata);
    checks++;
    if (rdata !== 32'h8000_0030) begin
      errors++;
      $display("FAIL store_fault_mepc: got %h required 80000030", rdata);
    end
    // Faulting load that also requests a CSR write to mcause: trap wins
    clear();
    bus.pc           = 32'h8000_0040;
    bus.dnpc_in      = 32'h8000_0044;
    bus.is_read      = 1'b1;
    bus.rd           = 4'd4;
    bus.gpr_we       = 1'b1;
    bus.load_data    = 32'h1234_5678;
    bus.access_fault = 1'b1;
    bus.csr_we       = 1'b1;
    bus.csr_addr     = 12'h342;
    bus.csr_wdata    = 32'h0000_DEAD;
    fire();
    checks++;
    if (bus.gpr_wen !== 1'b0 || bus.dnpc !== 32'h8000_1000) begin
      errors++;
      $display("FAIL load_fault_commit: wen=%b dnpc=%h required 0 80001000", bus.gpr_wen, bus.dnpc);
    end
    step();
    csr_read(12'h342, rdata);
    checks++;
    if (rdata !== 32'd5) begin
      errors++;
      $display("FAIL load_fault_mcause: got %h required 00000005", rdata);
    end
    csr_read(12'h341, rdata);
    checks++;
    if (rdata !== 32'h8000_0040) begin
      errors++;
      $display("FAIL load_fault_mepc: got %h required 80000040", rdata);
    end
  endtask

  task automatic test_rd0_readonly();
    clear();
    bus.rd         = 4'd0;
    bus.gpr_we     = 1'b1;
    bus.alu_result = 32'h0000_0055;
    bus.dnpc_in    = 32'h8000_0204;
    fire();
    checks++;
    if (bus.gpr_wen !== 1'b0 || bus.dnpc !== 32'h8000_0204) begin
      errors++;
      $display("FAIL rd0_write: wen=%b dnpc=%h required 0 80000204", bus.gpr_wen, bus.dnpc);
    end
    step();
    // csrrw x6, mvendorid, 0
    clear();
    bus.csr_en    = 1'b1;
    bus.csr_we    = 1'b1;
    bus.csr_addr  = 12'hF11;
    bus.csr_wdata = 32'd0;
    bus.rd        = 4'd6;
    bus.gpr_we    = 1'b1;
    fire();
    checks++;
    if (bus.gpr_wdata !== 32'h7973_7978 || bus.gpr_waddr !== 4'd6) begin
      errors++;
      $display("FAIL mvendorid_rw: wdata=%h waddr=%0d required 79737978 6",
               bus.gpr_wdata, bus.gpr_waddr);
    end
    step();
    csr_read(12'hF11, rdata);
    checks++;
    if (rdata !== 32'h7973_7978) begin
      errors++;
      $display("FAIL mvendorid_after: got %h required 79737978", rdata);
    end
    csr_read(12'hF12, rdata);
    checks++;
    if (rdata !== 32'h017D_C685) begin
      errors++;
      $display("FAIL marchid: got %h required 017dc685", rdata);
    end
    csr_read(12'h123, rdata);
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("FAIL unknown_csr: got %h required 00000000", rdata);
    end
  endtask

  task automatic test_back_to_back();
    clear();
    bus.rd         = 4'd9;
    bus.gpr_we     = 1'b1;
    bus.alu_result = 32'h0000_CAFE;
    bus.dnpc_in    = 32'h8000_0300;
    fire();
    checks++;
    if (bus.gpr_wen !== 1'b1 || bus.gpr_waddr !== 4'd9 || bus.gpr_wdata !== 32'h0000_CAFE ||
        bus.dnpc !== 32'h8000_0300) begin
      errors++;
      $display("FAIL b2b_first: wen=%b waddr=%0d wdata=%h dnpc=%h required 1 9 0000cafe 80000300",
               bus.gpr_wen, bus.gpr_waddr, bus.gpr_wdata, bus.dnpc);
    end
    // Next instruction offered immediately; captured on the IDLE edge
    bus.rd         = 4'd10;
    bus.alu_result = 32'h0000_BEEF;
    bus.dnpc_in    = 32'h8000_0304;
    bus.lsu_valid  = 1'b1;
    step();
    checks++;
    if (bus.wbu_ready !== 1'b1 || bus.gpr_wen !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: ready=%b wen=%b required 1 0", bus.wbu_ready, bus.gpr_wen);
    end
    step();
    bus.lsu_valid = 1'b0;
    checks++;
    if (bus.gpr_wen !== 1'b1 || bus.gpr_waddr !== 4'd10 || bus.gpr_wdata !== 32'h0000_BEEF ||
        bus.dnpc !== 32'h8000_0304) begin
      errors++;
      $display("FAIL b2b_second: wen=%b waddr=%0d wdata=%h dnpc=%h required 1 10 0000beef 80000304",
               bus.gpr_wen, bus.gpr_waddr, bus.gpr_wdata, bus.dnpc);
    end
    step();
  endtask

  task automatic test_reset_in_hold();
    clear();
    bus.csr_en    = 1'b1;
    bus.csr_we    = 1'b1;
    bus.csr_addr  = 12'h341;
    bus.csr_wdata = 32'h0000_1111;
    bus.dnpc_in   = 32'h8000_0400;
    bus.ifu_ready = 1'b0;
    fire();
    step();
    checks++;
    if (bus.wbu_valid !== 1'b1 || bus.wbu_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_entry: valid=%b ready=%b required 1 0", bus.wbu_valid, bus.wbu_ready);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.ifu_ready = 1'b1;
    checks++;
    if (bus.wbu_valid !== 1'b0 || bus.wbu_ready !== 1'b1 || bus.dnpc !== 32'd0) begin
      errors++;
      $display("FAIL hold_reset: valid=%b ready=%b dnpc=%h required 0 1 00000000",
               bus.wbu_valid, bus.wbu_ready, bus.dnpc);
    end
    csr_read(12'h341, rdata);
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("FAIL hold_reset_mepc: got %h required 00000000", rdata);
    end
    csr_read(12'h305, rdata);
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("FAIL hold_reset_mtvec: got %h required 00000000", rdata);
    end
    csr_read(12'h300, rdata);
    checks++;
    if (rdata !== 32'h0000_1800) begin
      errors++;
      $display("FAIL hold_reset_mstatus: got %h required 00001800", rdata);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    bus.ifu_ready = 1'b1;
    clear();
    test_reset();
    test_load_hold();
    test_trap();
    test_fault();
    test_rd0_readonly();
    test_back_to_back();
    test_reset_in_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a runaway simulation
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
